// File: rtl/lsu_pkg.sv
// Shared types and bus device map for the load/store unit.
// Device codes occupy address bits [15:12].
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_t;

  localparam logic [3:0] DEV_MEM  = 4'h0;
  localparam logic [3:0] DEV_FP   = 4'h1;
  localparam logic [3:0] DEV_HEX  = 4'h2;
  localparam logic [3:0] DEV_SW   = 4'h3;
  localparam logic [3:0] DEV_LEDR = 4'h4;
  localparam logic [3:0] DEV_KEY  = 4'h5;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating cycle counter that flags a hung bus transaction.
// TIMEOUT of zero never expires.
module bus_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [W-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/lsu_bus_master.sv
// Memory-stage bus master: one load/store at a time, strobe held
// until DataDone, load result handed to writeback, timeout abort.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int DEST_W  = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  input  logic              ReqWrite,
  input  logic [15:0]       ReqAddr,
  input  logic [15:0]       ReqData,
  input  logic [DEST_W-1:0] ReqDest,
  output logic              ReqReady,
  output logic              Stall,
  output logic              ReadData,
  output logic              WriteData,
  output logic [15:0]       DataAddr,
  output logic [15:0]       BusIn,
  input  logic [15:0]       BusOut,
  input  logic              DataDone,
  output logic              RespValid,
  output logic [15:0]       RespData,
  output logic [DEST_W-1:0] RespDest,
  input  logic              RespReady,
  output logic              BusError
);

  lsu_state_t state;
  lsu_state_t state_nx;

  logic              lat_write;
  logic [DEST_W-1:0] lat_dest;
  logic              accept;
  logic              in_req;
  logic              done;
  logic              expired;
  logic              abort;

  assign accept = (state == IDLE) && ReqValid;
  assign in_req = (state == REQ);
  assign done   = in_req && DataDone;
  // DataDone on the expiry cycle still counts as a clean completion
  assign abort  = expired && !DataDone;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_ctr (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (accept),
    .enable  (in_req),
    .expired (expired)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (ReqValid) state_nx = REQ;
      end
      REQ: begin
        if (done || abort) begin
          state_nx = lat_write ? IDLE : RESP;
        end
      end
      RESP: begin
        if (RespReady) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      DataAddr  <= '0;
      BusIn     <= '0;
      lat_write <= 1'b0;
      lat_dest  <= '0;
      RespData  <= '0;
      RespDest  <= '0;
      BusError  <= 1'b0;
    end else begin
      if (accept) begin
        DataAddr  <= ReqAddr;
        BusIn     <= ReqData;
        lat_write <= ReqWrite;
        lat_dest  <= ReqDest;
      end
      if (done && !lat_write) begin
        RespData <= BusOut;
        RespDest <= lat_dest;
      end else if (abort && !lat_write) begin
        RespData <= '0;
        RespDest <= lat_dest;
      end
      if (abort) BusError <= 1'b1;
    end
  end

  assign ReqReady  = (state == IDLE);
  assign Stall     = ReqValid && !ReqReady;
  assign ReadData  = in_req && !lat_write;
  assign WriteData = in_req && lat_write;
  assign RespValid = (state == RESP);

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench: driver queues expectations, monitors check
// bus strobes and writeback responses independently.
module tb_lsu_bus_master;
  import lsu_pkg::*;

  localparam int TO    = 4;
  localparam int NEVER = -1;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqWrite;
  logic [15:0] ReqAddr;
  logic [15:0] ReqData;
  logic [2:0]  ReqDest;
  logic        ReqReady;
  logic        Stall;
  logic        ReadData;
  logic        WriteData;
  logic [15:0] DataAddr;
  logic [15:0] BusIn;
  logic [15:0] BusOut;
  logic        DataDone;
  logic        RespValid;
  logic [15:0] RespData;
  logic [2:0]  RespDest;
  logic        RespReady;
  logic        BusError;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    int          cyc;
    logic        to;
  } sexp_t;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  dst;
  } rexp_t;

  typedef struct {
    int          lat;
    logic [15:0] bo;
  } bm_t;

  sexp_t exp_q[$];
  rexp_t resp_q[$];
  bm_t   bm_q[$];

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  bit exp_err = 1'b0;

  lsu_bus_master #(
    .TIMEOUT (TO),
    .DEST_W  (3)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .ReqValid  (ReqValid),
    .ReqWrite  (ReqWrite),
    .ReqAddr   (ReqAddr),
    .ReqData   (ReqData),
    .ReqDest   (ReqDest),
    .ReqReady  (ReqReady),
    .Stall     (Stall),
    .ReadData  (ReadData),
    .WriteData (WriteData),
    .DataAddr  (DataAddr),
    .BusIn     (BusIn),
    .BusOut    (BusOut),
    .DataDone  (DataDone),
    .RespValid (RespValid),
    .RespData  (RespData),
    .RespDest  (RespDest),
    .RespReady (RespReady),
    .BusError  (BusError)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bus model: completes each strobe run after its scheduled latency
  initial begin
    int  cnt;
    bm_t b;
    cnt = 0;
    b = '{NEVER, 16'h0};
    DataDone = 1'b0;
    BusOut = 16'h0;
    forever begin
      @(negedge Clock);
      if (ReadData || WriteData) begin
        if (cnt == 0) begin
          if (bm_q.size() > 0) b = bm_q.pop_front();
          else b = '{NEVER, 16'h0};
        end
        cnt++;
        DataDone = (b.lat != NEVER) && (cnt == b.lat + 1);
        BusOut = DataDone ? b.bo : 16'($urandom);
      end else begin
        cnt = 0;
        DataDone = 1'($urandom_range(0, 1));
        BusOut = 16'($urandom);
      end
    end
  end

  // Strobe monitor
  initial begin
    bit    run;
    int    cnt;
    sexp_t e;
    run = 1'b0;
    cnt = 0;
    e = '{1'b0, 16'h0, 16'h0, 0, 1'b0};
    forever begin
      @(negedge Clock);
      #2;
      if (mon_en) begin
        if (ReadData || WriteData) begin
          if (!run) begin
            run = 1'b1;
            cnt = 0;
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
            end else begin
              chk("spurious_strobe", 32'({ReadData, WriteData}), 32'(0));
              e = '{WriteData, DataAddr, BusIn, 0, 1'b0};
            end
          end
          cnt++;
          chk("strobe_sel", 32'({ReadData, WriteData}),
              32'(e.w ? 2'b01 : 2'b10));
          chk("data_addr", 32'(DataAddr), 32'(e.a));
          if (e.w) chk("bus_in", 32'(BusIn), 32'(e.d));
          chk("stall", 32'(Stall), 32'(ReqValid));
        end else if (run) begin
          run = 1'b0;
          chk("strobe_len", 32'(cnt), 32'(e.cyc));
          if (e.to) exp_err = 1'b1;
          chk("bus_error", 32'(BusError), 32'(exp_err));
          chk("ready_after", 32'(ReqReady), 32'(e.w));
        end
      end
    end
  end

  // Writeback monitor: holds RespReady low for a random number of cycles
  initial begin
    int    hold;
    bit    popped;
    rexp_t r;
    hold = 3;
    popped = 1'b0;
    RespReady = 1'b0;
    forever begin
      @(negedge Clock);
      #2;
      if (!mon_en) begin
        RespReady = 1'b0;
        popped = 1'b0;
      end else begin
        if (popped) begin
          chk("idle_after_resp", 32'(ReqReady), 32'(1));
          chk("valid_after_resp", 32'(RespValid), 32'(0));
        end
        popped = 1'b0;
        if (RespValid) begin
          if (resp_q.size() == 0) begin
            chk("spurious_resp", 32'(RespValid), 32'(0));
            RespReady = 1'b1;
          end else begin
            r = resp_q[0];
            chk("resp_data", 32'(RespData), 32'(r.d));
            chk("resp_dest", 32'(RespDest), 32'(r.dst));
            if (hold > 0) begin
              hold--;
              RespReady = 1'b0;
            end else begin
              RespReady = 1'b1;
              void'(resp_q.pop_front());
              popped = 1'b1;
              hold = $urandom_range(0, 3);
            end
          end
        end else begin
          RespReady = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [2:0] dst,
                       input int lat, input logic [15:0] bo);
    bit to;
    int n;
    to = (lat == NEVER);
    n = 0;
    exp_q.push_back('{w, a, d, (to ? TO : lat + 1), to});
    bm_q.push_back('{lat, bo});
    if (!w) resp_q.push_back('{(to ? 16'h0 : bo), dst});
    ReqValid = 1'b1;
    ReqWrite = w;
    ReqAddr = a;
    ReqData = d;
    ReqDest = dst;
    while (!ReqReady && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (!ReqReady) chk("accept_wait", 32'(ReqReady), 32'(1));
    @(negedge Clock);
  endtask

  task automatic idle(input int n);
    ReqValid = 1'b0;
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    logic [3:0] devs[6];
    int n;
    devs = '{DEV_MEM, DEV_FP, DEV_HEX, DEV_SW, DEV_LEDR, DEV_KEY};
    Reset = 1'b1;
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    ReqAddr = 16'h0;
    ReqData = 16'h0;
    ReqDest = 3'd0;
    repeat (3) @(negedge Clock);
    #2;
    chk("rst_ready", 32'(ReqReady), 32'(1));
    chk("rst_strobes", 32'({ReadData, WriteData}), 32'(0));
    chk("rst_addr", 32'(DataAddr), 32'(0));
    chk("rst_busin", 32'(BusIn), 32'(0));
    chk("rst_valid", 32'(RespValid), 32'(0));
    chk("rst_rdata", 32'(RespData), 32'(0));
    chk("rst_rdest", 32'(RespDest), 32'(0));
    chk("rst_err", 32'(BusError), 32'(0));
    chk("rst_stall", 32'(Stall), 32'(0));
    @(negedge Clock);
    Reset = 1'b0;
    mon_en = 1'b1;
    @(negedge Clock);

    issue(1'b0, 16'h0010, 16'h0000, 3'd5, 1, 16'h1234);
    idle(1);
    issue(1'b1, 16'h4000, 16'hBEEF, 3'd0, 0, 16'h0);
    idle(2);
    issue(1'b1, 16'h4010, 16'h1111, 3'd1, 1, 16'h0);
    issue(1'b1, 16'h4020, 16'h2222, 3'd2, 0, 16'h0);
    idle(2);
    issue(1'b0, 16'h0020, 16'h0000, 3'd6, 3, 16'hCAFE);
    idle(1);
    issue(1'b0, 16'h0030, 16'h0000, 3'd7, NEVER, 16'hDEAD);
    idle(1);
    issue(1'b1, 16'h2000, 16'h5555, 3'd0, NEVER, 16'h0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      logic       w;
      logic [3:0] dv;
      int         lat;
      int         gap;
      w = 1'($urandom_range(0, 1));
      dv = devs[$urandom_range(0, 5)];
      lat = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
      gap = $urandom_range(0, 2);
      issue(w, {dv, 12'($urandom)}, 16'($urandom), 3'($urandom),
            lat, 16'($urandom));
      if (gap > 0) idle(gap);
    end
    idle(1);

    n = 0;
    while ((resp_q.size() > 0 || exp_q.size() > 0 || !ReqReady)
           && n < 200) begin
      @(negedge Clock);
      n++;
    end
    repeat (3) @(negedge Clock);
    chk("resp_q_drained", 32'(resp_q.size()), 32'(0));
    chk("strobe_q_drained", 32'(exp_q.size()), 32'(0));

    mon_en = 1'b0;
    @(negedge Clock);
    #2;
    chk("err_sticky", 32'(BusError), 32'(exp_err));

    @(negedge Clock);
    ReqValid = 1'b1;
    ReqWrite = 1'b0;
    ReqAddr = 16'h0040;
    ReqDest = 3'd3;
    @(negedge Clock);
    ReqValid = 1'b0;
    #2;
    chk("pre_rst_strobe", 32'(ReadData), 32'(1));
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    #2;
    chk("mid_rst_read", 32'(ReadData), 32'(0));
    chk("mid_rst_write", 32'(WriteData), 32'(0));
    chk("mid_rst_valid", 32'(RespValid), 32'(0));
    chk("mid_rst_ready", 32'(ReqReady), 32'(1));
    chk("mid_rst_err", 32'(BusError), 32'(0));
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: reached %0t without finishing", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
